ami_app_req_queue: RTL and testbench

// - Per-app, per-port request buffer directly downstream of the app-level address translator.
// - Accepts translated AMIRequests and checks each physical address against the app's partition.
// - Queues in-range requests in a FIFO and presents them to the memory-side arbiter.
// - Out-of-range requests are consumed and dropped; the fault is recorded for the host.

---
 rtl/ami_types_pkg.sv | 18 +
 rtl/ami_app_req_queue_fifo.sv | 63 ++++++
 rtl/ami_app_req_queue.sv | 77 +++++++
 tb/tb_ami_app_req_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ami_types_pkg.sv
// Shared AMI request types and per-app memory-partition defaults.
package AMITypes;

  localparam int AMI_APP_BITS        = 4;
  localparam int AMI_NUM_PORTS       = 2;
  localparam int AMI_APP_PART_SHIFT  = 33;
  localparam int AMI_REQ_QUEUE_DEPTH = 8;
  localparam int AMI_DATA_WIDTH      = 512;

  typedef struct packed {
    logic                      valid;
    logic                      isWrite;
    logic [63:0]               addr;
    logic [AMI_DATA_WIDTH-1:0] data;
    logic [5:0]                size;
  } AMIRequest;

endpackage

// File: rtl/ami_app_req_queue_fifo.sv
// Generic DEPTH-entry AMIRequest FIFO; head is presented registered, no empty bypass.
module ami_req_fifo
  import AMITypes::*;
#(
  parameter int DEPTH = AMI_REQ_QUEUE_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  AMIRequest                  i_data,
  input  logic                       i_pop,
  output AMIRequest                  o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  AMIRequest        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage is not reset; an empty queue drives an all-zero head instead.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_data = '0;
    if (!o_empty) begin
      o_data       = r_mem[r_rd_ptr];
      o_data.valid = 1'b1;
    end
  end

endmodule

// File: rtl/ami_app_req_queue.sv
// Per-app, per-port request queue: partition check, FIFO buffering, and
// sticky fault capture for requests that fall outside the app's partition.
module ami_app_req_queue
  import AMITypes::*;
#(
  parameter int DEPTH      = AMI_REQ_QUEUE_DEPTH,
  parameter int PART_SHIFT = AMI_APP_PART_SHIFT,
  parameter int APP_BITS   = AMI_APP_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enabled,
  input  logic [APP_BITS-1:0]    i_app_num,
  input  AMIRequest              i_in_req,
  output logic                   o_in_grant,
  output AMIRequest              o_out_req,
  input  logic                   i_out_grant,
  output logic [$clog2(DEPTH):0] o_occupancy,
  output logic                   o_fault,
  output logic [63:0]            o_fault_addr,
  output logic [15:0]            o_fault_cnt,
  input  logic                   i_fault_clr
);

  logic        w_in_range;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_drop;
  logic        w_pop;
  logic        r_fault;
  logic [63:0] r_fault_addr;
  logic [15:0] r_fault_cnt;

  assign w_in_range = ((i_in_req.addr >> PART_SHIFT) == 64'(i_app_num));
  // Full blocks push regardless of a same-cycle pop, keeping out_grant off the grant path.
  assign o_in_grant = i_enabled & i_in_req.valid & (~w_in_range | ~w_full);
  assign w_push     = o_in_grant & w_in_range;
  assign w_drop     = o_in_grant & ~w_in_range;
  assign w_pop      = o_out_req.valid & i_out_grant;

  ami_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (i_in_req),
    .i_pop   (w_pop),
    .o_data  (o_out_req),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_occupancy)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_fault_cnt  <= '0;
    end else if (i_fault_clr) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_fault_cnt  <= '0;
    end else if (w_drop) begin
      r_fault <= 1'b1;
      if (!r_fault)                r_fault_addr <= i_in_req.addr;
      if (r_fault_cnt != 16'hFFFF) r_fault_cnt  <= r_fault_cnt + 16'd1;
    end
  end

  assign o_fault      = r_fault;
  assign o_fault_addr = r_fault_addr;
  assign o_fault_cnt  = r_fault_cnt;

  logic w_unused;
  assign w_unused = w_empty;

endmodule

// File: tb/tb_ami_app_req_queue.sv
// Directed plus randomized bench for ami_app_req_queue against a queue-based model.
module tb_ami_app_req_queue;
  import AMITypes::*;

  localparam int DEPTH = 8;
  localparam int SHIFT = 33;

  logic            clk = 1'b0;
  logic            rst;
  logic            enabled;
  logic [AMI_APP_BITS-1:0] app_num;
  AMIRequest       in_req;
  logic            in_grant;
  AMIRequest       out_req;
  logic            out_grant;
  logic [3:0]      occupancy;
  logic            fault;
  logic [63:0]     fault_addr;
  logic [15:0]     fault_cnt;
  logic            fault_clr;

  int checks   = 0;
  int failures = 0;

  AMIRequest   q[$];
  logic        m_fault;
  logic [63:0] m_faddr;
  int          m_fcnt;

  always #5 clk = ~clk;

  ami_app_req_queue #(.DEPTH(DEPTH), .PART_SHIFT(SHIFT), .APP_BITS(AMI_APP_BITS)) dut (
    .i_clk(clk), .i_rst(rst), .i_enabled(enabled), .i_app_num(app_num),
    .i_in_req(in_req), .o_in_grant(in_grant), .o_out_req(out_req),
    .i_out_grant(out_grant), .o_occupancy(occupancy), .o_fault(fault),
    .o_fault_addr(fault_addr), .o_fault_cnt(fault_cnt), .i_fault_clr(fault_clr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chkreq(input string tag, input AMIRequest got, input AMIRequest exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic AMIRequest mkreq(input logic [63:0] addr);
    AMIRequest r;
    r.valid   = 1'b1;
    r.isWrite = 1'($urandom);
    r.addr    = addr;
    for (int i = 0; i < AMI_DATA_WIDTH / 32; i++) r.data[i*32 +: 32] = $urandom;
    r.size    = 6'($urandom);
    return r;
  endfunction

  function automatic void model_clear();
    q.delete();
    m_fault = 1'b0;
    m_faddr = '0;
    m_fcnt  = 0;
  endfunction

  task automatic check_outputs();
    AMIRequest head;
    chk("out_valid", 64'(out_req.valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      head       = q[0];
      head.valid = 1'b1;
      chkreq("out_req", out_req, head);
    end
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("fault", 64'(fault), 64'(m_fault));
    chk("fault_addr", fault_addr, m_faddr);
    chk("fault_cnt", 64'(fault_cnt), 64'(m_fcnt));
  endtask

  // One clock cycle: starts and ends at a falling edge.
  task automatic cyc(input AMIRequest req, input logic en, input logic og, input logic clr);
    logic inr, eg;
    in_req = req; enabled = en; out_grant = og; fault_clr = clr;
    #1;
    inr = ((req.addr >> SHIFT) == 64'(app_num));
    eg  = en & req.valid & (~inr | (q.size() < DEPTH));
    chk("in_grant", 64'(in_grant), 64'(eg));
    check_outputs();
    @(posedge clk);
    if (og && q.size() > 0) void'(q.pop_front());
    if (eg && inr) q.push_back(req);
    if (clr) begin
      m_fault = 1'b0; m_faddr = '0; m_fcnt = 0;
    end else if (eg && !inr) begin
      if (!m_fault) m_faddr = req.addr;
      m_fault = 1'b1;
      if (m_fcnt < 65535) m_fcnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    AMIRequest   idle;
    logic [63:0] a;
    logic [63:0] lo;
    logic [30:0] part;
    idle = '0;
    rst = 1'b0; enabled = 1'b0; app_num = 4'd2; in_req = '0;
    out_grant = 1'b0; fault_clr = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_grant", 64'(in_grant), 64'd0);
    check_outputs();
    @(negedge clk);

    // In-order return with one-cycle latency.
    for (int i = 0; i < 3; i++) cyc(mkreq(64'h4_0000_0000 + 64'(i) * 64'h40), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(idle, 1'b1, 1'b1, 1'b0);

    // Fill to full with the arbiter stalled; the ninth push is refused.
    for (int i = 0; i < 9; i++) cyc(mkreq(64'h4_0000_1000 + 64'(i) * 64'h40), 1'b1, 1'b0, 1'b0);

    // Out-of-partition requests are dropped even while full.
    app_num = 4'd1;
    cyc(mkreq(64'h4_0000_0040), 1'b1, 1'b0, 1'b0);
    cyc(mkreq(64'h6_0000_0000), 1'b1, 1'b0, 1'b0);
    cyc(idle, 1'b1, 1'b0, 1'b1);
    cyc(idle, 1'b1, 1'b0, 1'b0);

    // Drain to 4 then push+pop every cycle across pointer wrap.
    for (int i = 0; i < 4; i++) cyc(idle, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(mkreq(64'h2_0000_0000 + 64'(i) * 64'h40), 1'b1, 1'b1, 1'b0);

    // Disable with entries queued; they keep draining.
    cyc(idle, 1'b1, 1'b1, 1'b0);
    cyc(mkreq(64'h2_0000_0800), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(mkreq(64'h2_0000_0840), 1'b0, 1'b1, 1'b0);

    // Clear with a same-cycle drop: the drop is not counted.
    cyc(mkreq(64'h8_0000_0000), 1'b1, 1'b0, 1'b0);
    cyc(mkreq(64'h8_0000_0040), 1'b1, 1'b0, 1'b1);
    cyc(idle, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with varied backpressure.
    for (int i = 0; i < 600; i++) begin
      lo = {$urandom, $urandom} & 64'h1_FFFF_FFFF;
      case ($urandom_range(0, 7))
        0:       part = 31'($urandom);
        1, 2:    part = 31'($urandom_range(0, 15));
        default: part = 31'(app_num);
      endcase
      a = (64'(part) << SHIFT) | lo;
      in_req = mkreq(a);
      in_req.valid = ($urandom_range(0, 3) != 0);
      cyc(in_req, ($urandom_range(0, 7) != 0),
          (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset between edges during a burst.
    for (int i = 0; i < 3; i++) cyc(mkreq(64'h2_0000_0000 + 64'(i) * 64'h40), 1'b1, 1'b0, 1'b0);
    cyc(mkreq(64'hA_0000_0000), 1'b1, 1'b0, 1'b0);
    in_req = mkreq(64'h2_0000_0100); enabled = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_req.valid), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_fault", 64'(fault), 64'd0);
    chk("arst_fault_cnt", 64'(fault_cnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cyc(idle, 1'b1, 1'b1, 1'b0);
    cyc(mkreq(64'h2_0000_0000), 1'b1, 1'b1, 1'b0);
    cyc(idle, 1'b1, 1'b1, 1'b0);
    cyc(idle, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
